// File: rtl/axi_mem_slave.sv
// Single-outstanding memory slave: services one write (AW -> W -> B) or one read (AR -> R)
// at a time against a register-file memory that is cleared by reset.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | ready for a new request; writes win over reads
// W_DATA | address latched, waiting for write data
// W_RESP | write committed, presenting write response
// R_WAIT | counting down read wait states
// R_DATA | presenting read data until accepted
module axi_mem_slave #(
    parameter int ADDR_W    = 7,
    parameter int DATA_W    = 32,
    parameter int READ_WAIT = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic              aw_valid,
    output logic              aw_ready,
    input  logic              ar_valid,
    output logic              ar_ready,
    input  logic [DATA_W-1:0] write_data,
    input  logic              wdata_valid,
    output logic              wdata_ready,
    output logic [DATA_W-1:0] read_data,
    output logic              rdata_valid,
    input  logic              rdata_ready,
    output logic              b_valid,
    input  logic              b_ready
);

    localparam int         DEPTH     = 1 << ADDR_W;
    localparam logic [3:0] WAIT_INIT = 4'(READ_WAIT);

    typedef enum logic [2:0] {IDLE, W_DATA, W_RESP, R_WAIT, R_DATA} state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [3:0]        wait_cnt_q;
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic aw_hs, ar_hs, w_hs, b_hs, r_hs;

    // Handshake outputs are decoded from state and forced low while reset is held.
    assign aw_ready    = reset && (state_q == IDLE);
    assign ar_ready    = reset && (state_q == IDLE) && !aw_valid;
    assign wdata_ready = reset && (state_q == W_DATA);
    assign b_valid     = reset && (state_q == W_RESP);
    assign rdata_valid = reset && (state_q == R_DATA);
    assign read_data   = rdata_q;

    assign aw_hs = aw_valid    && aw_ready;
    assign ar_hs = ar_valid    && ar_ready;
    assign w_hs  = wdata_valid && wdata_ready;
    assign b_hs  = b_valid     && b_ready;
    assign r_hs  = rdata_valid && rdata_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            wait_cnt_q <= '0;
            rdata_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (aw_hs) begin
                        addr_q  <= mem_addr;
                        state_q <= W_DATA;
                    end else if (ar_hs) begin
                        addr_q     <= mem_addr;
                        wait_cnt_q <= WAIT_INIT;
                        if (READ_WAIT == 0) begin
                            rdata_q <= mem_q[mem_addr];
                            state_q <= R_DATA;
                        end else begin
                            state_q <= R_WAIT;
                        end
                    end
                end
                W_DATA: if (w_hs) state_q <= W_RESP;
                W_RESP: if (b_hs) state_q <= IDLE;
                R_WAIT: begin
                    wait_cnt_q <= wait_cnt_q - 4'd1;
                    if (wait_cnt_q == 4'd1) begin
                        rdata_q <= mem_q[addr_q];
                        state_q <= R_DATA;
                    end
                end
                R_DATA: if (r_hs) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // A write lands at the W handshake edge, so a later read sees it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (w_hs) begin
            mem_q[addr_q] <= write_data;
        end
    end

endmodule

// File: tb/tb_axi_mem_slave.sv
// Directed bench for axi_mem_slave: one instance with no read wait states, one with three.
// Read expectations go into per-instance queues and are checked by a monitor at each R handshake.
module tb_axi_mem_slave;

    localparam int AW = 7;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [AW-1:0] mem_addr    [2];
    logic          aw_valid    [2];
    logic          aw_ready    [2];
    logic          ar_valid    [2];
    logic          ar_ready    [2];
    logic [DW-1:0] write_data  [2];
    logic          wdata_valid [2];
    logic          wdata_ready [2];
    logic [DW-1:0] read_data   [2];
    logic          rdata_valid [2];
    logic          rdata_ready [2];
    logic          b_valid     [2];
    logic          b_ready     [2];

    axi_mem_slave #(.ADDR_W(AW), .DATA_W(DW), .READ_WAIT(0)) u_dut0 (
        .clk(clk), .reset(reset), .mem_addr(mem_addr[0]),
        .aw_valid(aw_valid[0]), .aw_ready(aw_ready[0]),
        .ar_valid(ar_valid[0]), .ar_ready(ar_ready[0]),
        .write_data(write_data[0]), .wdata_valid(wdata_valid[0]), .wdata_ready(wdata_ready[0]),
        .read_data(read_data[0]), .rdata_valid(rdata_valid[0]), .rdata_ready(rdata_ready[0]),
        .b_valid(b_valid[0]), .b_ready(b_ready[0])
    );

    axi_mem_slave #(.ADDR_W(AW), .DATA_W(DW), .READ_WAIT(3)) u_dut3 (
        .clk(clk), .reset(reset), .mem_addr(mem_addr[1]),
        .aw_valid(aw_valid[1]), .aw_ready(aw_ready[1]),
        .ar_valid(ar_valid[1]), .ar_ready(ar_ready[1]),
        .write_data(write_data[1]), .wdata_valid(wdata_valid[1]), .wdata_ready(wdata_ready[1]),
        .read_data(read_data[1]), .rdata_valid(rdata_valid[1]), .rdata_ready(rdata_ready[1]),
        .b_valid(b_valid[1]), .b_ready(b_ready[1])
    );

    typedef struct {
        logic [DW-1:0] data;
        logic [AW-1:0] addr;
    } rexp_t;

    rexp_t exp_q0 [$];
    rexp_t exp_q1 [$];
    int    vectors     = 0;
    int    miscompares = 0;
    rexp_t mon_e;
    bit    mon_got;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int d, input logic [AW-1:0] a, input logic [DW-1:0] data);
        rexp_t e;
        e.addr = a;
        e.data = data;
        if (d == 0) exp_q0.push_back(e);
        else        exp_q1.push_back(e);
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (reset === 1'b1 && rdata_valid[d] === 1'b1 && rdata_ready[d] === 1'b1) begin
                mon_got = 1'b0;
                if (d == 0 && exp_q0.size() > 0) begin
                    mon_e = exp_q0.pop_front();
                    mon_got = 1'b1;
                end else if (d == 1 && exp_q1.size() > 0) begin
                    mon_e = exp_q1.pop_front();
                    mon_got = 1'b1;
                end
                if (mon_got)
                    check($sformatf("rdata_inst%0d_addr%02h", d, mon_e.addr), read_data[d], mon_e.data);
                else begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_rdata_inst%0d: got %h, expected no read", d, read_data[d]);
                end
            end
        end
    end

    task automatic do_write(input int d, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                            input int wdelay, input int bhold);
        int n;
        mem_addr[d] = a;
        aw_valid[d] = 1'b1;
        n = 0;
        @(negedge clk);
        while (aw_ready[d] !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("aw_accept_inst%0d", d), 32'(n < 50), 1);
        tick();
        aw_valid[d] = 1'b0;
        check($sformatf("wdata_ready_after_aw_inst%0d", d), wdata_ready[d], 1);
        check($sformatf("aw_ready_in_wdata_inst%0d", d), aw_ready[d], 0);
        for (int i = 0; i < wdelay; i++) begin
            check($sformatf("wdata_ready_stall_inst%0d", d), wdata_ready[d], 1);
            check($sformatf("b_valid_early_inst%0d", d), b_valid[d], 0);
            tick();
        end
        write_data[d]  = wd;
        wdata_valid[d] = 1'b1;
        tick();
        wdata_valid[d] = 1'b0;
        check($sformatf("b_valid_after_w_inst%0d", d), b_valid[d], 1);
        for (int i = 0; i < bhold; i++) begin
            check($sformatf("b_valid_hold_inst%0d", d), b_valid[d], 1);
            check($sformatf("aw_ready_bstall_inst%0d", d), aw_ready[d], 0);
            check($sformatf("ar_ready_bstall_inst%0d", d), ar_ready[d], 0);
            tick();
        end
        b_ready[d] = 1'b1;
        tick();
        b_ready[d] = 1'b0;
        check($sformatf("b_valid_after_b_inst%0d", d), b_valid[d], 0);
        check($sformatf("aw_ready_after_b_inst%0d", d), aw_ready[d], 1);
    endtask

    task automatic do_read(input int d, input logic [AW-1:0] a, input logic [DW-1:0] exp_data,
                           input int wait_n, input int rhold);
        int n;
        push_exp(d, a, exp_data);
        mem_addr[d] = a;
        ar_valid[d] = 1'b1;
        n = 0;
        @(negedge clk);
        while (ar_ready[d] !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("ar_accept_inst%0d", d), 32'(n < 50), 1);
        tick();
        ar_valid[d] = 1'b0;
        for (int i = 0; i < wait_n; i++) begin
            check($sformatf("rdata_valid_early_inst%0d_c%0d", d, i + 1), rdata_valid[d], 0);
            tick();
        end
        check($sformatf("rdata_valid_latency_inst%0d", d), rdata_valid[d], 1);
        for (int i = 0; i < rhold; i++) begin
            check($sformatf("rdata_valid_hold_inst%0d", d), rdata_valid[d], 1);
            check($sformatf("read_data_hold_inst%0d", d), read_data[d], exp_data);
            check($sformatf("aw_ready_rstall_inst%0d", d), aw_ready[d], 0);
            tick();
        end
        rdata_ready[d] = 1'b1;
        tick();
        rdata_ready[d] = 1'b0;
        check($sformatf("rdata_valid_after_r_inst%0d", d), rdata_valid[d], 0);
        check($sformatf("aw_ready_after_r_inst%0d", d), aw_ready[d], 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        for (int d = 0; d < 2; d++) begin
            mem_addr[d] = '0;    aw_valid[d] = 1'b0;    ar_valid[d] = 1'b0;
            write_data[d] = '0;  wdata_valid[d] = 1'b0; rdata_ready[d] = 1'b0;
            b_ready[d] = 1'b0;
        end
        #2 reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("rst_aw_ready_inst%0d", d), aw_ready[d], 0);
            check($sformatf("rst_ar_ready_inst%0d", d), ar_ready[d], 0);
            check($sformatf("rst_wdata_ready_inst%0d", d), wdata_ready[d], 0);
            check($sformatf("rst_b_valid_inst%0d", d), b_valid[d], 0);
            check($sformatf("rst_rdata_valid_inst%0d", d), rdata_valid[d], 0);
            check($sformatf("rst_read_data_inst%0d", d), read_data[d], 0);
        end
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("post_rst_aw_ready_inst%0d", d), aw_ready[d], 1);
            check($sformatf("post_rst_ar_ready_inst%0d", d), ar_ready[d], 1);
        end
        tick();

        do_read(0, 7'h7F, 32'h0000_0000, 0, 0);
        do_write(0, 7'h05, 32'hDEAD_BEEF, 0, 0);
        do_read(0, 7'h05, 32'hDEAD_BEEF, 0, 0);

        // Simultaneous AW/AR: write must win, read served only after B.
        mem_addr[0] = 7'h10;
        write_data[0] = 32'hA5A5_0010;
        aw_valid[0] = 1'b1;
        ar_valid[0] = 1'b1;
        @(negedge clk);
        check("simul_ar_ready_idle", ar_ready[0], 0);
        check("simul_aw_ready_idle", aw_ready[0], 1);
        tick();
        aw_valid[0] = 1'b0;
        check("simul_wdata_ready", wdata_ready[0], 1);
        check("simul_ar_ready_wdata", ar_ready[0], 0);
        wdata_valid[0] = 1'b1;
        tick();
        wdata_valid[0] = 1'b0;
        check("simul_b_valid", b_valid[0], 1);
        check("simul_ar_ready_wresp", ar_ready[0], 0);
        push_exp(0, 7'h10, 32'hA5A5_0010);
        b_ready[0] = 1'b1;
        tick();
        b_ready[0] = 1'b0;
        check("simul_ar_ready_after_b", ar_ready[0], 1);
        check("simul_rdata_valid_before_ar", rdata_valid[0], 0);
        tick();
        ar_valid[0] = 1'b0;
        check("simul_rdata_valid", rdata_valid[0], 1);
        rdata_ready[0] = 1'b1;
        tick();
        rdata_ready[0] = 1'b0;
        check("simul_rdata_valid_after_r", rdata_valid[0], 0);

        do_write(0, 7'h7F, 32'h1234_5678, 1, 5);
        do_read(0, 7'h7F, 32'h1234_5678, 0, 5);

        do_write(1, 7'h33, 32'hCAFE_F00D, 2, 0);
        do_read(1, 7'h33, 32'hCAFE_F00D, 3, 0);
        do_read(1, 7'h05, 32'h0000_0000, 3, 2);
        do_read(0, 7'h33, 32'h0000_0000, 0, 0);
        do_read(0, 7'h05, 32'hDEAD_BEEF, 0, 0);
        do_read(0, 7'h10, 32'hA5A5_0010, 0, 0);

        // Reset while in W_DATA: pending write is dropped, memory cleared.
        mem_addr[0] = 7'h20;
        aw_valid[0] = 1'b1;
        tick();
        aw_valid[0] = 1'b0;
        check("midwr_wdata_ready", wdata_ready[0], 1);
        write_data[0] = 32'h5555_AAAA;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("midwr_rst_wdata_ready", wdata_ready[0], 0);
        check("midwr_rst_aw_ready", aw_ready[0], 0);
        check("midwr_rst_ar_ready", ar_ready[0], 0);
        tick();
        tick();
        reset = 1'b1;
        #1;
        check("midwr_release_aw_ready", aw_ready[0], 1);
        tick();
        do_read(0, 7'h20, 32'h0000_0000, 0, 0);
        do_read(0, 7'h05, 32'h0000_0000, 0, 0);
        do_read(1, 7'h33, 32'h0000_0000, 3, 0);
        do_write(0, 7'h20, 32'h0BAD_F00D, 0, 0);
        do_read(0, 7'h20, 32'h0BAD_F00D, 0, 0);

        // Reset while read data is stalled: valid and data drop at once.
        mem_addr[0] = 7'h20;
        ar_valid[0] = 1'b1;
        tick();
        ar_valid[0] = 1'b0;
        check("midrd_rdata_valid", rdata_valid[0], 1);
        check("midrd_read_data", read_data[0], 32'h0BAD_F00D);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("midrd_rst_rdata_valid", rdata_valid[0], 0);
        check("midrd_rst_read_data", read_data[0], 0);
        tick();
        reset = 1'b1;
        tick();
        check("midrd_release_aw_ready", aw_ready[0], 1);

        repeat (2) tick();
        check("exp_q0_drained", 32'(exp_q0.size()), 0);
        check("exp_q1_drained", 32'(exp_q1.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
